// File: rtl/mat_fifo_stream_out.sv
// mat_fifo_stream_out
// Streams one image frame (IMG_WIDTH x IMG_HEIGHT beats) out of an upstream
// show-ahead FIFO onto a valid/ready stream, tagging each beat with
// start-of-frame, end-of-line and end-of-frame flags.
//
// Handshake: a beat transfers on every rising edge where m_valid and m_ready
// are both 1. While m_valid=1 and m_ready=0, m_data and the tags hold.
// m_valid never depends on m_ready. The upstream pop (fifo_rd_en) is derived
// from registered state and fifo_empty only, so there is no combinational
// path from m_ready to fifo_rd_en.
//
// A 2-entry skid buffer sits between the FIFO and the stream. A word popped
// on an edge is presented on m_data from the next cycle. Popping stops when
// both entries are full.
//
// Optional feature: define MAT_STREAM_STALL_CNT_EN to add the 16-bit
// stall_cnt output, which counts backpressured cycles in the current frame.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = RUN, 2 = DRAIN.
module mat_fifo_stream_out #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  busy,
    output logic                  frame_done,
`ifdef MAT_STREAM_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic [1:0]            dbg_state
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] LAST_COL   = CNT_W'(IMG_WIDTH - 1);

    // Tag bit positions inside a buffer entry.
    localparam int TAG_SOF = 0;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]      col_q, col_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [2:0]            buf_tag_q  [2];
    logic [2:0]            buf_tag_d  [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    logic                  pop;
    logic                  accept;
    logic                  head_eof;
    logic [2:0]            fetch_tag;

`ifdef MAT_STREAM_STALL_CNT_EN
    logic [15:0]           stall_cnt_q, stall_cnt_d;
`endif

    // Pop and accept strobes plus the tags of the word being fetched.
    always_comb begin
        pop = 1'b0;
        if ((state_q == S_RUN) && !rd_rst && !fifo_empty &&
            (occ_q < 2'd2) && (fetch_cnt_q < TOTAL_C)) begin
            pop = 1'b1;
        end
        accept   = (occ_q != 2'd0) && m_ready;
        head_eof = buf_tag_q[rd_ptr_q][TAG_EOF];

        fetch_tag          = 3'b000;
        fetch_tag[TAG_SOF] = (col_q == '0) && (row_q == '0);
        fetch_tag[TAG_EOL] = (col_q == LAST_COL);
        fetch_tag[TAG_EOF] = (fetch_cnt_q == LAST_BEAT);
    end

    // Frame FSM: next state, fetch/column/row counters and the done pulse.
    always_comb begin
        state_d      = state_q;
        fetch_cnt_d  = fetch_cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d     = S_RUN;
                    fetch_cnt_d = '0;
                    col_d       = '0;
                    row_d       = '0;
                end
            end

            S_RUN: begin
                // frame_start is ignored here; only pops advance the frame.
                if (pop) begin
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (fetch_cnt_q == LAST_BEAT) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // The eof beat can only be in the buffer here, because it is
                // popped on the same edge that enters DRAIN.
                if (accept && head_eof) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-entry skid buffer: write on pop, read on accept, track occupancy.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_tag_d  = buf_tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q + 2'(pop) - 2'(accept);

        if (pop) begin
            buf_data_d[wr_ptr_q] = fifo_rd_data;
            buf_tag_d[wr_ptr_q]  = fetch_tag;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (accept) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

`ifdef MAT_STREAM_STALL_CNT_EN
    // Saturating count of backpressured cycles, cleared when a frame starts.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && frame_start) begin
            stall_cnt_d = '0;
        end else if ((occ_q != 2'd0) && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // State, counters and buffer registers with synchronous reset.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q       <= S_IDLE;
            fetch_cnt_q   <= '0;
            col_q         <= '0;
            row_q         <= '0;
            frame_done_q  <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_tag_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_cnt_q   <= fetch_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_done_q  <= frame_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= buf_data_d[i];
                buf_tag_q[i]  <= buf_tag_d[i];
            end
        end
    end

    assign fifo_rd_en = pop;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf_data_q[rd_ptr_q];
    assign m_sof      = m_valid && buf_tag_q[rd_ptr_q][TAG_SOF];
    assign m_eol      = m_valid && buf_tag_q[rd_ptr_q][TAG_EOL];
    assign m_eof      = m_valid && buf_tag_q[rd_ptr_q][TAG_EOF];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mat_fifo_stream_out.sv
// Directed bench for mat_fifo_stream_out with a 4x2 frame and 16-bit beats.
// An upstream show-ahead FIFO model feeds the DUT, and a negedge monitor
// records the accepted beats. Each comparison is an immediate assertion.
module tb_mat_fifo_stream_out;

    localparam int DW = 16;
    localparam int BW = DW + 3;   // {eof, eol, sof, data}

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          frame_done;
    logic [1:0]    dbg_state;
`ifdef MAT_STREAM_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    mat_fifo_stream_out #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2)
    ) dut (
        .rd_clk       (clk),
        .rd_rst       (rst),
        .frame_start  (frame_start),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sof        (m_sof),
        .m_eol        (m_eol),
        .m_eof        (m_eof),
        .busy         (busy),
        .frame_done   (frame_done),
`ifdef MAT_STREAM_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream show-ahead FIFO model.
    logic [DW-1:0] mem [0:63];
    int            wr_idx = 0;
    int            rd_idx = 0;
    logic          gap;
    logic          flush;

    assign fifo_empty   = (rd_idx == wr_idx) || gap;
    assign fifo_rd_data = mem[rd_idx[5:0]];

    always @(posedge clk) begin
        if (flush) rd_idx <= wr_idx;
        else if (fifo_rd_en) rd_idx <= rd_idx + 1;
    end

    // Monitor: records accepted beats, hold violations and illegal pops.
    logic [BW-1:0] got_arr [0:255];
    int            got_wr    = 0;
    int            hold_viol = 0;
    int            pop_viol  = 0;
    int            done_cnt  = 0;
    logic          stall_prev = 1'b0;
    logic [BW-1:0] prev_beat  = '0;
    logic [BW-1:0] cur;

    always @(negedge clk) begin
        cur = {m_eof, m_eol, m_sof, m_data};
        if (rst) begin
            if (fifo_rd_en) pop_viol++;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (cur !== prev_beat)) hold_viol++;
            if (fifo_rd_en && (fifo_empty || !busy)) pop_viol++;
            if (m_valid && m_ready) begin
                got_arr[got_wr[7:0]] = cur;
                got_wr++;
            end
            if (frame_done) done_cnt++;
            stall_prev = m_valid && !m_ready;
            prev_beat  = cur;
        end
    end

    // Scoreboard state and counters.
    logic [BW-1:0] exp_q [$];
    int            got_rd = 0;
    int            errors = 0;
    int            checks = 0;
    int            done_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        for (int i = 0; i < 8; i++) begin
            mem[wr_idx % 64] = 16'(base + i);
            wr_idx++;
        end
    endtask

    task automatic push_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == 7), (i % 4 == 3), (i == 0), 16'(base + i)});
        end
    endtask

    task automatic score(input string tag, input int n_exp);
        chk({tag, "_beat_count"}, 32'(got_wr - got_rd), n_exp);
        while ((got_rd < got_wr) && (exp_q.size() > 0)) begin
            chk(tag, 32'(got_arr[got_rd[7:0]]), 32'(exp_q.pop_front()));
            got_rd++;
        end
        got_rd = got_wr;
        exp_q.delete();
        chk({tag, "_hold"}, 32'(hold_viol), 0);
        chk({tag, "_pop"}, 32'(pop_viol), 0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((frame_done !== 1'b1) && (n < budget)) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(frame_done), 1);
    endtask

    task automatic start_frame();
        done_base   = done_cnt;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1; frame_start = 1'b0; m_ready = 1'b0; gap = 1'b0; flush = 1'b0;
        done_base = 0;
        step();
        step();

        // Reset state.
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_tags", 32'({m_sof, m_eol, m_eof}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_state", 32'(dbg_state), 0);
`ifdef MAT_STREAM_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
        rst = 1'b0;
        step();

        // Continuous flow: beats 0..7 on consecutive cycles.
        load(0);
        push_frame(0, 8);
        m_ready = 1'b1;
        start_frame();
        chk("cf_state_run", 32'(dbg_state), 1);
        chk("cf_busy", 32'(busy), 1);
        chk("cf_first_pop", 32'(fifo_rd_en), 1);
        chk("cf_no_valid_yet", 32'(m_valid), 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("cf_valid", 32'(m_valid), 1);
            chk("cf_data", 32'(m_data), k);
            chk("cf_tags", 32'({m_sof, m_eol, m_eof}),
                32'({(k == 0), (k == 3 || k == 7), (k == 7)}));
        end
        step();
        chk("cf_frame_done", 32'(frame_done), 1);
        chk("cf_idle", 32'(dbg_state), 0);
        chk("cf_valid_off", 32'(m_valid), 0);
        step();
        chk("cf_done_pulse", 32'(frame_done), 0);
        chk("cf_done_cnt", 32'(done_cnt - done_base), 1);
        score("cf", 8);

        // Backpressure: m_ready low for four cycles after beat 0 is taken.
        load(32'h20);
        push_frame(32'h20, 8);
        start_frame();
`ifdef MAT_STREAM_STALL_CNT_EN
        chk("bp_stall_cleared", 32'(stall_cnt), 0);
`endif
        step();
        step();
        m_ready = 1'b0;
        step();
        chk("bp_pop_stop", 32'(fifo_rd_en), 0);
        chk("bp_data_hold", 32'(m_data), 32'h21);
        step();
        step();
        chk("bp_pop_still_off", 32'(fifo_rd_en), 0);
        chk("bp_valid_hold", 32'(m_valid), 1);
        chk("bp_data_hold2", 32'(m_data), 32'h21);
        step();
        m_ready = 1'b1;
        wait_done("bp", 40);
        step();
`ifdef MAT_STREAM_STALL_CNT_EN
        chk("bp_stall_cnt", 32'(stall_cnt), 4);
        step();
        chk("bp_stall_held", 32'(stall_cnt), 4);
`endif
        chk("bp_done_cnt", 32'(done_cnt - done_base), 1);
        score("bp", 8);

        // Upstream gaps: fifo_empty forced every other cycle.
        load(32'h40);
        push_frame(32'h40, 8);
        start_frame();
`ifdef MAT_STREAM_STALL_CNT_EN
        chk("gap_stall_cleared", 32'(stall_cnt), 0);
`endif
        for (int n = 0; n < 60 && frame_done !== 1'b1; n++) begin
            gap = ~gap;
            step();
        end
        gap = 1'b0;
        chk("gap_done_seen", 32'(frame_done), 1);
        step();
        chk("gap_done_cnt", 32'(done_cnt - done_base), 1);
        score("gap", 8);

        // Reset mid-frame, right after beat 2 is accepted.
        load(32'h60);
        push_frame(32'h60, 3);
        start_frame();
        step();
        step();
        step();
        step();
        chk("mr_beat3_shown", 32'(m_data), 32'h63);
        rst = 1'b1;
        frame_start = 1'b1;
        m_ready = 1'b0;
        #1;
        chk("mr_no_pop_in_reset", 32'(fifo_rd_en), 0);
        step();
        rst = 1'b0;
        frame_start = 1'b0;
        #1;
        chk("mr_valid", 32'(m_valid), 0);
        chk("mr_data", 32'(m_data), 0);
        chk("mr_tags", 32'({m_sof, m_eol, m_eof}), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(frame_done), 0);
        chk("mr_rd_en", 32'(fifo_rd_en), 0);
        chk("mr_state", 32'(dbg_state), 0);
`ifdef MAT_STREAM_STALL_CNT_EN
        chk("mr_stall", 32'(stall_cnt), 0);
`endif
        score("mr_pre", 3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mr_start_ignored", 32'(busy), 0);
        load(32'h80);
        push_frame(32'h80, 8);
        m_ready = 1'b1;
        start_frame();
        step();
        chk("mr_new_sof", 32'(m_sof), 1);
        chk("mr_new_data", 32'(m_data), 32'h80);
        wait_done("mr", 40);
        step();
        chk("mr_done_cnt", 32'(done_cnt - done_base), 1);
        score("mr", 8);

        // Ignored restart: frame_start pulsed in RUN and again in DRAIN.
        load(32'hA0);
        push_frame(32'hA0, 8);
        start_frame();
        step();
        step();
        step();
        chk("ir_in_run", 32'(dbg_state), 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        step();
        step();
        chk("ir_in_drain", 32'(dbg_state), 2);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("ir_frame_done", 32'(frame_done), 1);
        chk("ir_idle", 32'(dbg_state), 0);
        for (int n = 0; n < 5; n++) step();
        chk("ir_no_restart", 32'(busy), 0);
        chk("ir_done_cnt", 32'(done_cnt - done_base), 1);
        score("ir", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mat_fifo_stream_out.md
MAT_FIFO_STREAM_OUT -- requirements
Module: mat_fifo_stream_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel/beat width 1..256.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, beats per line, 2..4095.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame, 1..4095.
REQ-004 SHALL have port rd_clk  input  1  sole clock; one clock domain; every register on rising edge.
REQ-005 SHALL have port rd_rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port frame_start  input  1  single-cycle request to stream one frame.
REQ-007 SHALL have port fifo_rd_data  input  DATA_WIDTH  head word of upstream show-ahead FIFO; valid while fifo_empty=0.
REQ-008 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-009 SHALL have port fifo_rd_en  output  1  pops the FIFO head word.
REQ-010 SHALL have ports m_data (output, DATA_WIDTH), m_valid (output, 1) and m_ready (input, 1) forming the downstream valid/ready stream.
REQ-011 SHALL have ports m_sof, m_eol and m_eof, each output 1: start-of-frame, end-of-line and end-of-frame tags, qualified by m_valid.
REQ-012 SHALL have ports busy (output, 1; state != IDLE) and frame_done (output, 1; one-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE, RUN, DRAIN; IDLE->RUN on frame_start=1, clearing fetch and tag counters.
REQ-014 SHALL go RUN->DRAIN on the cycle the last word (fetch count reaching IMG_WIDTH*IMG_HEIGHT) is popped.
REQ-015 SHALL go DRAIN->IDLE on the cycle the m_eof beat is accepted (m_valid & m_ready), pulsing frame_done on that same edge for exactly one cycle.
REQ-016 SHALL ignore frame_start while in RUN or DRAIN (no restart, no queueing).
REQ-017 SHALL drive fifo_rd_en = RUN & ~fifo_empty & (occupancy<2) & (fetch_cnt < total), purely from registers and fifo_empty, never combinationally from m_ready.
REQ-018 SHALL capture fifo_rd_data into a 2-entry buffer on the popping edge, so the beat is presented on m_data with m_valid=1 from the next cycle (latency 1).
REQ-019 SHALL compute tags at fetch: sof at column 0/row 0; eol at column IMG_WIDTH-1; eof at the final beat; column wraps IMG_WIDTH-1->0 and increments row.
REQ-020 SHALL hold m_data and tags stable while m_valid=1 and m_ready=0, and present beats in FIFO order.
REQ-021 SHALL sustain 1 beat/cycle when m_ready=1 and fifo_empty=0.
REQ-022 SHALL handle occupancy boundaries: at occupancy 1, simultaneous pop and accept keeps occupancy 1; at occupancy 2, no pop.
REQ-023 SHALL size counters at ceil(log2(IMG_WIDTH*IMG_HEIGHT+1)) bits with no overflow; the FIFO is never popped outside RUN.

Reset
REQ-024 SHALL, while rd_rst=1, force state IDLE, occupancy 0, all counters 0, and fifo_rd_en, m_valid, m_sof, m_eol, m_eof, busy, frame_done and stall_cnt to 0 (m_data 0).
REQ-025 SHALL, on rd_rst mid-frame, discard buffered beats, pop nothing on the reset cycle, and ignore frame_start asserted during reset.

Configuration
REQ-026 SHALL, with macro MAT_STREAM_STALL_CNT_EN defined, add output stall_cnt (16 bits) counting cycles with m_valid=1 & m_ready=0 in the current frame: saturating at 16'hFFFF, cleared on IDLE->RUN, held after frame_done.
REQ-027 SHALL, without MAT_STREAM_STALL_CNT_EN, omit the stall_cnt port and its logic entirely, leaving all other behaviour identical.

Verification
REQ-028 SHALL verify continuous flow: IMG_WIDTH=4, IMG_HEIGHT=2, FIFO preloaded with 8 words 0..7, m_ready=1, frame_start pulse -> beats 0..7 on consecutive cycles; sof on 0, eol on 3 and 7, eof on 7; frame_done one cycle after beat 7 accepted.
REQ-029 SHALL verify backpressure: same frame, m_ready=0 for cycles 3..6 -> fifo_rd_en stops after occupancy 2, m_data stable, no beat lost or duplicated; stall_cnt=4 with macro defined.
REQ-030 SHALL verify upstream gaps: fifo_empty toggles every other cycle -> fifo_rd_en only when fifo_empty=0, output order 0..7 intact.
REQ-031 SHALL verify reset mid-frame: rd_rst for 1 cycle after beat 2 -> all outputs 0 next cycle, state IDLE, no pop on the reset cycle; a new frame_start then starts at sof.
REQ-032 SHALL verify ignored restart: frame_start re-pulsed during RUN and during DRAIN -> no counter change, exactly 8 beats and one frame_done.
